// File: rtl/amb_denetleyici_pkg.sv
// amb_denetleyici_pkg: FSM states, branch codes and default widths for the execute controller
package amb_denetleyici_pkg;
  localparam int YAZMAC_BIT = 5;
  localparam int UOP_AMB_BIT = 6;
  typedef enum logic [1:0] {
    BOS   = 2'd0,
    YURUT = 2'd1,
    CIKIS = 2'd2
  } durum_t;
  localparam logic [2:0] DAL_YOK  = 3'd0;
  localparam logic [2:0] DAL_BEQ  = 3'd1;
  localparam logic [2:0] DAL_BNE  = 3'd2;
  localparam logic [2:0] DAL_BLT  = 3'd3;
  localparam logic [2:0] DAL_BGE  = 3'd4;
  localparam logic [2:0] DAL_BLTU = 3'd5;
  localparam logic [2:0] DAL_BGEU = 3'd6;
endpackage

// File: rtl/amb_denetleyici_dal_cozucu.sv
// dal_cozucu: maps a branch type and the ALU compare flags to the taken bit
module dal_cozucu
  import amb_denetleyici_pkg::*;
(
  input  logic [2:0] dal_i,
  input  logic       esittir_i,
  input  logic       kucuktur_i,
  input  logic       kucuktur_isaretsiz_i,
  output logic       atla_o
);
  // each branch type picks one flag or its inverse; none/reserved never jump
  always_comb
    atla_o = (dal_i == DAL_BEQ)  ?  esittir_i :
             (dal_i == DAL_BNE)  ? !esittir_i :
             (dal_i == DAL_BLT)  ?  kucuktur_i :
             (dal_i == DAL_BGE)  ? !kucuktur_i :
             (dal_i == DAL_BLTU) ?  kucuktur_isaretsiz_i :
             (dal_i == DAL_BGEU) ? !kucuktur_isaretsiz_i : 1'b0;
endmodule

// File: rtl/amb_denetleyici.sv
// amb_denetleyici: execute-stage ALU controller; AMB_YONLENDIRME_EN enables forwarding from the output register
module amb_denetleyici
  import amb_denetleyici_pkg::*;
#(
  parameter int VERI_BIT   = 32,
  parameter int UOP_BIT    = UOP_AMB_BIT,
  parameter int YAZMAC_BIT = amb_denetleyici_pkg::YAZMAC_BIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  temizle_i,
  input  logic                  giris_gecerli_i,
  output logic                  giris_hazir_o,
  input  logic [UOP_BIT-1:0]    giris_kod_i,
  input  logic [VERI_BIT-1:0]   giris_islec1_i,
  input  logic [VERI_BIT-1:0]   giris_islec2_i,
  input  logic [YAZMAC_BIT-1:0] giris_rs1_i,
  input  logic [YAZMAC_BIT-1:0] giris_rs2_i,
  input  logic [YAZMAC_BIT-1:0] giris_rd_i,
  input  logic                  giris_yaz_i,
  input  logic [2:0]            giris_dal_i,
  input  logic [VERI_BIT-1:0]   giris_hedef_i,
  output logic [UOP_BIT-1:0]    amb_kod_o,
  output logic                  amb_gecerli_o,
  output logic [VERI_BIT-1:0]   amb_islec1_o,
  output logic [VERI_BIT-1:0]   amb_islec2_o,
  input  logic [VERI_BIT-1:0]   amb_sonuc_i,
  input  logic                  amb_sonuc_gecerli_i,
  input  logic                  amb_esittir_i,
  input  logic                  amb_kucuktur_i,
  input  logic                  amb_kucuktur_isaretsiz_i,
  output logic                  cikis_gecerli_o,
  input  logic                  cikis_hazir_i,
  output logic [VERI_BIT-1:0]   cikis_sonuc_o,
  output logic [YAZMAC_BIT-1:0] cikis_rd_o,
  output logic                  cikis_yaz_o,
  output logic                  cikis_dal_atla_o,
  output logic [VERI_BIT-1:0]   cikis_dal_hedef_o
);
  durum_t                r_durum;
  logic                  r_amb_gecerli;
  logic                  r_cikis_gecerli;
  logic [UOP_BIT-1:0]    r_kod;
  logic [VERI_BIT-1:0]   r_islec1;
  logic [VERI_BIT-1:0]   r_islec2;
  logic [YAZMAC_BIT-1:0] r_rd;
  logic                  r_yaz;
  logic [2:0]            r_dal;
  logic [VERI_BIT-1:0]   r_hedef;
  logic [VERI_BIT-1:0]   r_sonuc;
  logic [YAZMAC_BIT-1:0] r_cikis_rd;
  logic                  r_cikis_yaz;
  logic                  r_atla;
  logic [VERI_BIT-1:0]   r_cikis_hedef;
  logic                  w_kabul;
  logic                  w_atla;
  logic [VERI_BIT-1:0]   w_islec1;
  logic [VERI_BIT-1:0]   w_islec2;

  // a new packet fits when idle, or when the held result leaves this same cycle
  always_comb begin
    giris_hazir_o = (r_durum == BOS) || (r_durum == CIKIS && cikis_hazir_i);
    w_kabul = giris_gecerli_i && giris_hazir_o;
  end

`ifdef AMB_YONLENDIRME_EN
  logic w_ileri;
  // the result leaving now is the newest value of its rd, so it overrides stale decode operands
  always_comb begin
    w_ileri  = (r_durum == CIKIS) && r_cikis_yaz && (r_cikis_rd != '0);
    w_islec1 = (w_ileri && giris_rs1_i == r_cikis_rd) ? r_sonuc : giris_islec1_i;
    w_islec2 = (w_ileri && giris_rs2_i == r_cikis_rd) ? r_sonuc : giris_islec2_i;
  end
`else
  logic w_unused;
  // without forwarding decode resolves hazards, so source addresses are ignored
  always_comb begin
    w_unused = ^{giris_rs1_i, giris_rs2_i};
    w_islec1 = giris_islec1_i;
    w_islec2 = giris_islec2_i;
  end
`endif

  dal_cozucu u_dal_cozucu (
    .dal_i                (r_dal),
    .esittir_i            (amb_esittir_i),
    .kucuktur_i           (amb_kucuktur_i),
    .kucuktur_isaretsiz_i (amb_kucuktur_isaretsiz_i),
    .atla_o               (w_atla)
  );

  // FSM: latch a packet, hold the ALU inputs until it finishes, then hold the writeback packet
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum         <= BOS;
      r_amb_gecerli   <= 1'b0;
      r_cikis_gecerli <= 1'b0;
      r_kod           <= '0;
      r_islec1        <= '0;
      r_islec2        <= '0;
      r_rd            <= '0;
      r_yaz           <= 1'b0;
      r_dal           <= '0;
      r_hedef         <= '0;
      r_sonuc         <= '0;
      r_cikis_rd      <= '0;
      r_cikis_yaz     <= 1'b0;
      r_atla          <= 1'b0;
      r_cikis_hedef   <= '0;
    end else if (temizle_i) begin
      r_durum         <= BOS;
      r_amb_gecerli   <= 1'b0;
      r_cikis_gecerli <= 1'b0;
    end else begin
      case (r_durum)
        BOS: if (giris_gecerli_i) begin
          r_durum       <= YURUT;
          r_amb_gecerli <= 1'b1;
        end
        YURUT: if (amb_sonuc_gecerli_i) begin
          r_durum         <= CIKIS;
          r_amb_gecerli   <= 1'b0;
          r_cikis_gecerli <= 1'b1;
          r_sonuc         <= amb_sonuc_i;
          r_cikis_rd      <= r_rd;
          r_cikis_yaz     <= r_yaz;
          r_atla          <= w_atla;
          r_cikis_hedef   <= r_hedef;
        end
        CIKIS: if (cikis_hazir_i) begin
          r_durum         <= giris_gecerli_i ? YURUT : BOS;
          r_amb_gecerli   <= giris_gecerli_i;
          r_cikis_gecerli <= 1'b0;
        end
        default: r_durum <= BOS;
      endcase
      if (w_kabul) begin
        r_kod    <= giris_kod_i;
        r_islec1 <= w_islec1;
        r_islec2 <= w_islec2;
        r_rd     <= giris_rd_i;
        r_yaz    <= giris_yaz_i;
        r_dal    <= giris_dal_i;
        r_hedef  <= giris_hedef_i;
      end
    end
  end

  // every ALU-facing and writeback output comes straight from a register
  always_comb begin
    amb_gecerli_o     = r_amb_gecerli;
    amb_kod_o         = r_kod;
    amb_islec1_o      = r_islec1;
    amb_islec2_o      = r_islec2;
    cikis_gecerli_o   = r_cikis_gecerli;
    cikis_sonuc_o     = r_sonuc;
    cikis_rd_o        = r_cikis_rd;
    cikis_yaz_o       = r_cikis_yaz;
    cikis_dal_atla_o  = r_atla;
    cikis_dal_hedef_o = r_cikis_hedef;
  end
endmodule

// File: tb/tb_amb_denetleyici.sv
// tb_amb_denetleyici: directed and random checks of the execute controller against a packet-level model
module tb_amb_denetleyici;
  import amb_denetleyici_pkg::*;
  localparam int UB = UOP_AMB_BIT;
  localparam logic [UB-1:0] K_ADD = 1, K_SUB = 2, K_MUL = 3, K_AND = 4, K_OR = 5;

  logic clk_i = 0, rst_i = 1, temizle_i = 0, giris_gecerli_i = 0, giris_hazir_o;
  logic [UB-1:0] giris_kod_i = '0, amb_kod_o;
  logic [31:0] giris_islec1_i = '0, giris_islec2_i = '0, giris_hedef_i = '0;
  logic [4:0] giris_rs1_i = '0, giris_rs2_i = '0, giris_rd_i = '0, cikis_rd_o;
  logic giris_yaz_i = 0;
  logic [2:0] giris_dal_i = '0;
  logic amb_gecerli_o, amb_sonuc_gecerli_i, amb_esittir_i, amb_kucuktur_i, amb_kucuktur_isaretsiz_i;
  logic [31:0] amb_islec1_o, amb_islec2_o, amb_sonuc_i, cikis_sonuc_o, cikis_dal_hedef_o;
  logic cikis_gecerli_o, cikis_hazir_i = 0, cikis_yaz_o, cikis_dal_atla_o;

  int checks = 0, errors = 0;
  logic [UB-1:0] ek;
  logic [31:0] ea, eb, esonuc, ehedef, onceki_sonuc;
  logic [4:0] erd, onceki_rd;
  logic eyaz, eatla, onceki_var = 0, onceki_yaz;
  int egec;

  amb_denetleyici dut (
    .clk_i(clk_i), .rst_i(rst_i), .temizle_i(temizle_i),
    .giris_gecerli_i(giris_gecerli_i), .giris_hazir_o(giris_hazir_o),
    .giris_kod_i(giris_kod_i), .giris_islec1_i(giris_islec1_i), .giris_islec2_i(giris_islec2_i),
    .giris_rs1_i(giris_rs1_i), .giris_rs2_i(giris_rs2_i), .giris_rd_i(giris_rd_i),
    .giris_yaz_i(giris_yaz_i), .giris_dal_i(giris_dal_i), .giris_hedef_i(giris_hedef_i),
    .amb_kod_o(amb_kod_o), .amb_gecerli_o(amb_gecerli_o),
    .amb_islec1_o(amb_islec1_o), .amb_islec2_o(amb_islec2_o),
    .amb_sonuc_i(amb_sonuc_i), .amb_sonuc_gecerli_i(amb_sonuc_gecerli_i),
    .amb_esittir_i(amb_esittir_i), .amb_kucuktur_i(amb_kucuktur_i),
    .amb_kucuktur_isaretsiz_i(amb_kucuktur_isaretsiz_i),
    .cikis_gecerli_o(cikis_gecerli_o), .cikis_hazir_i(cikis_hazir_i),
    .cikis_sonuc_o(cikis_sonuc_o), .cikis_rd_o(cikis_rd_o), .cikis_yaz_o(cikis_yaz_o),
    .cikis_dal_atla_o(cikis_dal_atla_o), .cikis_dal_hedef_o(cikis_dal_hedef_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int gecikme(input logic [UB-1:0] k);
    return (k == K_MUL) ? 4 : (k == K_OR) ? 3 : 1;
  endfunction

  function automatic logic [31:0] hesapla(input logic [UB-1:0] k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      K_ADD: return a + b;
      K_SUB: return a - b;
      K_MUL: return a * b;
      K_AND: return a & b;
      K_OR:  return a | b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic dal_ref(input logic [2:0] d, input logic [31:0] a, input logic [31:0] b);
    case (d)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return $signed(a) < $signed(b);
      3'd4: return $signed(a) >= $signed(b);
      3'd5: return a < b;
      3'd6: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // ALU model: result after a per-opcode latency, counter cleared whenever valid drops
  int alu_sayac;
  always @(posedge clk_i or posedge rst_i)
    if (rst_i || !amb_gecerli_o) alu_sayac <= 0;
    else alu_sayac <= alu_sayac + 1;
  assign amb_sonuc_gecerli_i = amb_gecerli_o && (alu_sayac == gecikme(amb_kod_o) - 1);
  assign amb_sonuc_i = amb_sonuc_gecerli_i ? hesapla(amb_kod_o, amb_islec1_o, amb_islec2_o) : 32'h0;
  assign amb_esittir_i = amb_islec1_o == amb_islec2_o;
  assign amb_kucuktur_i = $signed(amb_islec1_o) < $signed(amb_islec2_o);
  assign amb_kucuktur_isaretsiz_i = amb_islec1_o < amb_islec2_o;

  task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] b);
    checks++;
    assert (g === b) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, g, b);
    end
  endtask

  task automatic gonder(input logic [UB-1:0] k, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic yaz, input logic [2:0] dal, input logic [31:0] hedef);
    bit kabul = 0;
    int deneme;
    ek = k; ea = a; eb = b;
`ifdef AMB_YONLENDIRME_EN
    if (onceki_var && onceki_yaz && onceki_rd != 0) begin
      if (rs1 == onceki_rd) ea = onceki_sonuc;
      if (rs2 == onceki_rd) eb = onceki_sonuc;
    end
`endif
    erd = rd; eyaz = yaz; ehedef = hedef;
    esonuc = hesapla(k, ea, eb); eatla = dal_ref(dal, ea, eb); egec = gecikme(k);
    @(negedge clk_i);
    giris_kod_i = k; giris_islec1_i = a; giris_islec2_i = b; giris_rs1_i = rs1; giris_rs2_i = rs2;
    giris_rd_i = rd; giris_yaz_i = yaz; giris_dal_i = dal; giris_hedef_i = hedef;
    giris_gecerli_i = 1; cikis_hazir_i = 1;
    for (deneme = 0; deneme < 20; deneme++) begin
      #1 kabul = giris_hazir_o;
      @(posedge clk_i);
      if (kabul) break;
      @(negedge clk_i);
    end
    chk("kabul_bekleme", deneme, 0);
    onceki_var = 0;
  endtask

  task automatic bekle();
    bit gordu = 0;
    int n = 0;
    for (int i = 1; i <= 12 && !gordu; i++) begin
      @(negedge clk_i);
      if (cikis_gecerli_o) begin
        gordu = 1;
        n = i;
      end else if (amb_gecerli_o) begin
        chk("amb_kod", amb_kod_o, ek);
        chk("amb_islec1", amb_islec1_o, ea);
        chk("amb_islec2", amb_islec2_o, eb);
        chk("hazir_yurut", giris_hazir_o, 0);
      end
      if (i == 1) begin
        giris_gecerli_i = 0;
        cikis_hazir_i = 0;
      end
    end
    chk("cikis_gecerli", gordu, 1);
    chk("gecikme", n, egec + 1);
    chk("sonuc", cikis_sonuc_o, esonuc);
    chk("rd", cikis_rd_o, erd);
    chk("yaz", cikis_yaz_o, eyaz);
    chk("dal_atla", cikis_dal_atla_o, eatla);
    chk("dal_hedef", cikis_dal_hedef_o, ehedef);
    onceki_var = 1; onceki_rd = erd; onceki_yaz = eyaz; onceki_sonuc = esonuc;
  endtask

  task automatic tut(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk_i);
      chk("tut_gecerli", cikis_gecerli_o, 1);
      chk("tut_hazir", giris_hazir_o, 0);
      chk("tut_sonuc", cikis_sonuc_o, esonuc);
      chk("tut_rd", cikis_rd_o, erd);
      chk("tut_amb_gecerli", amb_gecerli_o, 0);
    end
  endtask

  task automatic bosalt();
    @(negedge clk_i);
    cikis_hazir_i = 1;
    @(negedge clk_i);
    chk("bos_gecerli", cikis_gecerli_o, 0);
    chk("bos_hazir", giris_hazir_o, 1);
    cikis_hazir_i = 0;
    onceki_var = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit goruldu;
    @(negedge clk_i);
    chk("rst_hazir", giris_hazir_o, 1);
    chk("rst_amb_gecerli", amb_gecerli_o, 0);
    chk("rst_cikis_gecerli", cikis_gecerli_o, 0);
    chk("rst_sonuc", cikis_sonuc_o, 0);
    chk("rst_kod", amb_kod_o, 0);
    chk("rst_atla", cikis_dal_atla_o, 0);
    rst_i = 0;
    // ADD 5+7 -> 12 at N+2
    gonder(K_ADD, 5, 7, 0, 0, 3, 1, 3'd0, 0);
    bekle();
    bosalt();
    // multi-cycle MUL, operands stable throughout
    gonder(K_MUL, 32'h10000, 32'h10, 0, 0, 4, 1, 3'd0, 0);
    bekle();
    chk("mul_sonuc", cikis_sonuc_o, 32'h100000);
    bosalt();
    // branches
    gonder(K_SUB, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 3'd3, 32'h80);
    bekle();
    chk("blt_atla", cikis_dal_atla_o, 1);
    chk("blt_hedef", cikis_dal_hedef_o, 32'h80);
    gonder(K_SUB, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 3'd6, 32'h80);
    bekle();
    chk("bgeu_atla", cikis_dal_atla_o, 1);
    gonder(K_SUB, 4, 4, 0, 0, 0, 0, 3'd1, 32'h40);
    bekle();
    chk("beq_atla", cikis_dal_atla_o, 1);
    // downstream stall then simultaneous handshakes
    tut(5);
    gonder(K_AND, 32'hF0F0, 32'h0FF0, 0, 0, 7, 1, 3'd7, 32'h11);
    bekle();
    bosalt();
    // forwarding pair: rd=5 forwards, rd=0 never does
    gonder(K_ADD, 4, 5, 0, 0, 5, 1, 3'd0, 0);
    bekle();
    gonder(K_SUB, 0, 2, 5, 9, 6, 1, 3'd0, 0);
    bekle();
`ifdef AMB_YONLENDIRME_EN
    chk("ileri_rd5", cikis_sonuc_o, 7);
`else
    chk("ileri_yok", cikis_sonuc_o, 32'hFFFF_FFFE);
`endif
    bosalt();
    gonder(K_ADD, 4, 5, 0, 0, 0, 1, 3'd0, 0);
    bekle();
    gonder(K_SUB, 0, 2, 0, 9, 6, 1, 3'd0, 0);
    bekle();
    chk("ileri_rd0", cikis_sonuc_o, 32'hFFFF_FFFE);
    // flush while a result is held
    @(negedge clk_i);
    temizle_i = 1;
    @(negedge clk_i);
    temizle_i = 0;
    chk("temizle_cikis", cikis_gecerli_o, 0);
    onceki_var = 0;
    // flush during a multi-cycle op
    gonder(K_MUL, 3, 3, 0, 0, 1, 1, 3'd0, 0);
    @(negedge clk_i);
    giris_gecerli_i = 0;
    cikis_hazir_i = 1;
    @(negedge clk_i);
    temizle_i = 1;
    @(negedge clk_i);
    temizle_i = 0;
    chk("temizle_amb", amb_gecerli_o, 0);
    chk("temizle_hazir", giris_hazir_o, 1);
    goruldu = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      goruldu |= cikis_gecerli_o | amb_gecerli_o;
    end
    chk("temizle_sessiz", goruldu, 0);
    // flush wins over a same-cycle input handshake
    @(negedge clk_i);
    giris_kod_i = K_ADD;
    giris_gecerli_i = 1;
    temizle_i = 1;
    @(negedge clk_i);
    giris_gecerli_i = 0;
    temizle_i = 0;
    chk("temizle_kabul_yok", amb_gecerli_o, 0);
    cikis_hazir_i = 0;
    // async reset mid-op
    gonder(K_MUL, 32'h1234, 32'h5678, 0, 0, 2, 1, 3'd1, 32'h99);
    @(negedge clk_i);
    giris_gecerli_i = 0;
    @(negedge clk_i);
    #1 rst_i = 1;
    #1;
    chk("arst_amb_gecerli", amb_gecerli_o, 0);
    chk("arst_kod", amb_kod_o, 0);
    chk("arst_islec1", amb_islec1_o, 0);
    chk("arst_cikis", cikis_gecerli_o, 0);
    chk("arst_hazir", giris_hazir_o, 1);
    @(negedge clk_i);
    rst_i = 0;
    onceki_var = 0;
    // random traffic with back-to-back handshakes and stalls
    for (int n = 0; n < 40; n++) begin
      logic [UB-1:0] k;
      logic [31:0] a, b;
      k = K_ADD + UB'($urandom_range(0, 4));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      gonder(k, a, b, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      bekle();
      tut($urandom_range(0, 3));
    end
    bosalt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/amb_denetleyici.md
# amb_denetleyici

Execute-stage controller sitting directly upstream of the ALU (`amb`) and downstream of decode. It accepts one decoded ALU micro-op per valid/ready handshake and holds opcode and operands stable on the ALU inputs until the ALU reports completion. This covers both single-cycle ops and multi-cycle ops (MUL/MULH, HMDST, CNTZ, CNTP). It then registers the result, resolves conditional branches from the ALU compare flags, and presents a registered writeback packet to the next stage with its own valid/ready handshake.

## Interface
Parameters:
- `VERI_BIT`, default 32: operand and result width.
- `UOP_BIT`, default `UOP_AMB_BIT`: ALU opcode width.
- `YAZMAC_BIT`, default 5: register address width.

Ports:
- `clk_i` input, 1: single clock. All state changes on its rising edge.
- `rst_i` input, 1: asynchronous, active-high reset.
- `temizle_i` input, 1: synchronous flush. Has the highest priority after reset.
- `giris_gecerli_i` input, 1: decode packet valid.
- `giris_hazir_o` output, 1: controller can accept a packet.
- `giris_kod_i` input, `UOP_BIT`: ALU opcode.
- `giris_islec1_i`, `giris_islec2_i` input, `VERI_BIT`: operands.
- `giris_rs1_i`, `giris_rs2_i` input, `YAZMAC_BIT`: source register addresses (used only for forwarding).
- `giris_rd_i` input, `YAZMAC_BIT`: destination register.
- `giris_yaz_i` input, 1: op writes `rd`.
- `giris_dal_i` input, 3: branch type. 0 = none, 1 = BEQ, 2 = BNE, 3 = BLT, 4 = BGE, 5 = BLTU, 6 = BGEU, 7 = reserved (treated as none).
- `giris_hedef_i` input, `VERI_BIT`: branch target.
- `amb_kod_o` output, `UOP_BIT`: drives the ALU opcode input.
- `amb_gecerli_o` output, 1: drives the ALU op-valid input.
- `amb_islec1_o`, `amb_islec2_o` output, `VERI_BIT`: drive the ALU operand inputs.
- `amb_sonuc_i` input, `VERI_BIT`: ALU result.
- `amb_sonuc_gecerli_i` input, 1: ALU result valid.
- `amb_esittir_i`, `amb_kucuktur_i`, `amb_kucuktur_isaretsiz_i` input, 1: ALU compare flags (combinational on the operands).
- `cikis_gecerli_o` output, 1: writeback packet valid.
- `cikis_hazir_i` input, 1: downstream accepts the packet.
- `cikis_sonuc_o` output, `VERI_BIT`: registered result.
- `cikis_rd_o` output, `YAZMAC_BIT`: registered destination register.
- `cikis_yaz_o` output, 1: registered write enable.
- `cikis_dal_atla_o` output, 1: branch taken.
- `cikis_dal_hedef_o` output, `VERI_BIT`: registered branch target.

## Operation
FSM states and transitions:
- BOS: no packet held. `giris_hazir_o` = 1. On `giris_gecerli_i`, latch the packet and go to YURUT.
- YURUT: drive the ALU.
  - `amb_gecerli_o` = 1; `amb_kod_o` and the operands come from the latched registers and do not change while in this state.
  - When `amb_sonuc_gecerli_i` = 1: capture result, rd, yaz, hedef and the computed taken bit into the output registers, then go to CIKIS.
  - `giris_hazir_o` = 0.
- CIKIS: `cikis_gecerli_o` = 1. `amb_gecerli_o` = 0, which restarts the ALU's internal counter.
  - `giris_hazir_o` = `cikis_hazir_i` (combinational).
  - Handshake with a new input packet: latch it and go to YURUT.
  - Handshake with no new input: go to BOS.
  - Otherwise stay in CIKIS with all outputs stable.

Branch taken bit:
- BEQ = eq; BNE = !eq; BLT = lt; BGE = !lt; BLTU = ltu; BGEU = !ltu.
- All other branch codes give 0.
- Sampled in the same cycle as `amb_sonuc_gecerli_i`.

Flush (`temizle_i`):
- Go to BOS next edge; drop the latched and output packets.
- `cikis_gecerli_o` and `amb_gecerli_o` are 0 the following cycle.
- A same-cycle input handshake is ignored.

Reset: all registers cleared; state BOS. Every output is 0 during and after reset, except `giris_hazir_o` = 1.

## Timing
- Single-cycle op, packet accepted at edge N: ALU is driven during cycle N+1; `cikis_gecerli_o` is high from N+2.
- Multi-cycle op: `cikis_gecerli_o` rises one cycle after the first cycle in which `amb_sonuc_gecerli_i` is high.
- Back-to-back throughput: one packet every 2 cycles for single-cycle ops (CIKIS→YURUT overlap).
- The ALU inputs never change while `amb_gecerli_o` = 1 and `amb_sonuc_gecerli_i` = 0.
- Asynchronous reset in YURUT abandons the op. The ALU sees valid fall immediately and clears its own state on its next edge.

## Configuration
`AMB_YONLENDIRME_EN` enables operand forwarding from the output register.
- With the macro: when a packet is accepted while in CIKIS with `cikis_yaz_o` = 1 and `cikis_rd_o` ≠ 0:
  - If `giris_rs1_i` == `cikis_rd_o`, the latched operand 1 is `cikis_sonuc_o` instead of `giris_islec1_i`.
  - The same rule applies independently to rs2 / operand 2.
- Without the macro: operands are latched verbatim, rs addresses are unused, and decode must stall on hazards.

## Structure
- The shared package/header holds:
  - the FSM state encodings (BOS = 0, YURUT = 1, CIKIS = 2);
  - the branch-type constants `DAL_YOK`, `DAL_BEQ` … `DAL_BGEU`;
  - `YAZMAC_BIT`.
- The opcode constants remain in `mikroislem.vh`.
- One sub-module, `dal_cozucu`: combinational branch-type + flags → taken bit.

## Test plan
- ADD 5+7, rd = 3, downstream always ready → `cikis_gecerli_o` at N+2 with sonuc = 12, rd = 3, yaz = 1, dal_atla = 0.
- MUL 0x10000×0x10 with an ALU model giving valid after 4 cycles → ALU operands stable for all 4 cycles; sonuc = 0x100000 one cycle after ALU valid.
- BLT with −1 vs 1, hedef = 0x80 → dal_atla = 1, hedef = 0x80. BGEU with the same operands → dal_atla = 1. BEQ 4 vs 4 → 1.
- `cikis_hazir_i` held 0 for 5 cycles → packet and all outputs held stable, `giris_hazir_o` = 0. Then with ready = 1 and a new packet valid → both handshakes complete the same cycle.
- `temizle_i` pulsed during a multi-cycle op → next cycle BOS, `amb_gecerli_o` = 0, no `cikis_gecerli_o`. `rst_i` asserted mid-op → outputs 0 immediately.
- With `AMB_YONLENDIRME_EN`: ADD rd = 5 result 9, then SUB with rs1 = 5, stale islec1 = 0, islec2 = 2 → result 7. Same stimulus with rd = 0 → result −2.
